// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_scheduler
//  Purpose  : Round-robin owner of the shared pattern lane. It grants one
//             requester, drives a shifted burst, checks the looped-back
//             samples and returns a per-burst match result.
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int PAT_W      = 3,
  parameter int BURST_LEN  = 4,
  parameter int SAMPLE_LAT = 1,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int ERR_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*PAT_W-1:0] req_pattern_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     abort_i,
  output logic [PAT_W-1:0]         gen_pattern_o,
  output logic                     gen_active_o,
  input  logic [PAT_W-1:0]         sample_in_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output logic [ID_W-1:0]          done_id_o,
  output logic                     done_match_o,
  output logic                     done_aborted_o,
  output logic [ERR_W-1:0]         err_count_o
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int LAT_W  = (SAMPLE_LAT > 1) ? $clog2(SAMPLE_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]    drain_q, drain_d;
  logic [PAT_W-1:0]    gen_pattern_q, gen_pattern_d;
  logic                gen_active_q, gen_active_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                aborted_q, aborted_d;
  logic                flush_d;

  // Expected-value pipeline: stage 0 captures the beat currently on the bus,
  // so the last stage lines up with sample_in SAMPLE_LAT cycles after the beat.
  logic [PAT_W-1:0]    exp_val_q [SAMPLE_LAT];
  logic                exp_vld_q [SAMPLE_LAT];

  logic                w_found;
  logic [ID_W-1:0]     w_grant_idx;
  logic [PAT_W-1:0]    w_grant_pat;
  logic                w_mismatch;
  logic                w_abort_live;

  // Value driven on beat k of a burst with pattern p.
  function automatic logic [PAT_W-1:0] beat_value(input logic [PAT_W-1:0]  p,
                                                  input logic [BEAT_W-1:0] k);
    if (k == '0)
      return p;
    else if (k == BEAT_W'(BURST_LEN - 1))
      return '0;
    else
      return p << k;
  endfunction

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int idx;
    w_found     = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (!w_found && req_valid_i[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = ID_W'(idx);
      end
    end
    w_grant_pat = req_pattern_i[int'(w_grant_idx)*PAT_W +: PAT_W];
  end

  assign w_mismatch   = exp_vld_q[SAMPLE_LAT-1] &&
                        (exp_val_q[SAMPLE_LAT-1] != sample_in_i);
  assign w_abort_live = abort_i && ((state_q == S_RUN) || (state_q == S_DRAIN));

  // Next-state and output decode for the burst controller.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    pat_d         = pat_q;
    id_d          = id_q;
    beat_d        = beat_q;
    drain_d       = drain_q;
    gen_pattern_d = '0;
    gen_active_d  = 1'b0;
    aborted_d     = aborted_q;
    flush_d       = 1'b0;
    req_ready_o   = '0;
    err_d         = err_q;

    // An abort discards the comparison that would land in the same cycle.
    if (w_mismatch && !w_abort_live)
      err_d = err_q + ERR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          req_ready_o   = NUM_REQ'(1) << w_grant_idx;
          pat_d         = w_grant_pat;
          id_d          = w_grant_idx;
          last_grant_d  = w_grant_idx;
          beat_d        = '0;
          gen_pattern_d = w_grant_pat;
          gen_active_d  = 1'b1;
          err_d         = '0;
          aborted_d     = 1'b0;
          state_d       = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          flush_d   = 1'b1;
          state_d   = S_REPORT;
        end else if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          beat_d        = beat_q + BEAT_W'(1);
          gen_pattern_d = beat_value(pat_q, beat_q + BEAT_W'(1));
          gen_active_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          flush_d   = 1'b1;
          state_d   = S_REPORT;
        end else if (drain_q == LAT_W'(SAMPLE_LAT - 1)) begin
          state_d = S_REPORT;
        end else begin
          drain_d = drain_q + LAT_W'(1);
        end
      end
      S_REPORT: begin
        if (done_ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state, burst bookkeeping and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      pat_q         <= '0;
      id_q          <= '0;
      beat_q        <= '0;
      drain_q       <= '0;
      gen_pattern_q <= '0;
      gen_active_q  <= 1'b0;
      err_q         <= '0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      pat_q         <= pat_d;
      id_q          <= id_d;
      beat_q        <= beat_d;
      drain_q       <= drain_d;
      gen_pattern_q <= gen_pattern_d;
      gen_active_q  <= gen_active_d;
      err_q         <= err_d;
      aborted_q     <= aborted_d;
    end
  end

  // Expected-value shift pipeline; an abort clears every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SAMPLE_LAT; i++) begin
        exp_val_q[i] <= '0;
        exp_vld_q[i] <= 1'b0;
      end
    end else if (flush_d) begin
      for (int i = 0; i < SAMPLE_LAT; i++) begin
        exp_val_q[i] <= '0;
        exp_vld_q[i] <= 1'b0;
      end
    end else begin
      exp_val_q[0] <= gen_pattern_q;
      exp_vld_q[0] <= gen_active_q;
      for (int i = 1; i < SAMPLE_LAT; i++) begin
        exp_val_q[i] <= exp_val_q[i-1];
        exp_vld_q[i] <= exp_vld_q[i-1];
      end
    end
  end

  assign gen_pattern_o  = gen_pattern_q;
  assign gen_active_o   = gen_active_q;
  assign done_valid_o   = (state_q == S_REPORT);
  assign done_id_o      = id_q;
  assign done_aborted_o = (state_q == S_REPORT) && aborted_q;
  assign done_match_o   = (state_q == S_REPORT) && !aborted_q &&
                          (err_q == '0) && (pat_q != '0);
  assign err_count_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_scheduler
//  Purpose  : Self-checking bench for pattern_scheduler (4 requesters,
//             3-bit patterns, 4-beat bursts, 1-cycle sample latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_scheduler;

  localparam int NREQ = 4;
  localparam int PW   = 3;
  localparam int BL   = 4;
  localparam int SL   = 1;

  typedef struct {
    int unsigned id;
    bit          match;
    bit          aborted;
    int unsigned err;
  } result_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*PW-1:0] req_pattern;
  logic [NREQ-1:0]   req_ready;
  logic              abort;
  logic [PW-1:0]     gen_pattern;
  logic              gen_active;
  logic [PW-1:0]     sample_in;
  logic              done_valid;
  logic              done_ready;
  logic [1:0]        done_id;
  logic              done_match;
  logic              done_aborted;
  logic [2:0]        err_count;

  logic [PW-1:0]     gen_d1 = '0;
  bit                loop_mode;

  result_t           sb[$];
  int                checks = 0;
  int                errors = 0;

  pattern_scheduler #(
    .NUM_REQ(NREQ), .PAT_W(PW), .BURST_LEN(BL), .SAMPLE_LAT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_pattern_i(req_pattern), .req_ready_o(req_ready),
    .abort_i(abort), .gen_pattern_o(gen_pattern), .gen_active_o(gen_active),
    .sample_in_i(sample_in), .done_valid_o(done_valid), .done_ready_i(done_ready),
    .done_id_o(done_id), .done_match_o(done_match), .done_aborted_o(done_aborted),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  // Loopback path: one-cycle delayed copy of the bus, or stuck at zero.
  always @(posedge clk) gen_d1 <= gen_pattern;
  assign sample_in = loop_mode ? gen_d1 : '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] model_beat(input logic [PW-1:0] p, input int k);
    logic [PW-1:0] v;
    if (k == 0)           v = p;
    else if (k == BL - 1) v = '0;
    else                  v = PW'(p << k);
    return v;
  endfunction

  // Scoreboard consumer: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (!reset && done_valid && done_ready) begin
      result_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got id=%0d match=%0b abort=%0b err=%0d, none expected",
                 done_id, done_match, done_aborted, err_count);
      end else begin
        e = sb.pop_front();
        if (done_id !== 2'(e.id) || done_match !== e.match ||
            done_aborted !== e.aborted || err_count !== 3'(e.err)) begin
          errors++;
          $display("FAIL result: got id=%0d match=%0b abort=%0b err=%0d, want id=%0d match=%0b abort=%0b err=%0d",
                   done_id, done_match, done_aborted, err_count, e.id, e.match, e.aborted, e.err);
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; req_pattern = '0; abort = 1'b0;
    done_ready = 1'b0; loop_mode = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    #1;
    checks++;
    if ({gen_active, gen_pattern, done_valid, done_match, done_aborted, done_id, err_count, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: active=%0b pat=%0d dv=%0b m=%0b ab=%0b id=%0d err=%0d rdy=%b, want all 0",
               gen_active, gen_pattern, done_valid, done_match, done_aborted, done_id, err_count, req_ready);
    end
    tick;
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_rdy;
    result_t e;
    loop_mode   = 1'b1;
    done_ready  = 1'b1;
    req_pattern = {3'b100, 3'b011, 3'b010, 3'b001};
    req_valid   = '1;
    #1;
    for (int c = 0; c < 35; c++) begin
      exp_rdy = (c % 7 == 0 && c <= 28) ? NREQ'(1 << ((c / 7) % NREQ)) : '0;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: got %b want %b", c, req_ready, exp_rdy);
      end
      if (exp_rdy != '0) begin
        e = '{id: (c / 7) % NREQ, match: 1'b1, aborted: 1'b0, err: 0};
        sb.push_back(e);
      end
      tick;
      if (c == 28) req_valid = '0;
      #1;
    end
    done_ready = 1'b0;
  endtask

  // One complete burst granted to requester id out of mask, with beat and
  // timing checks; hold keeps done_ready low that many REPORT cycles.
  task automatic run_burst(input logic [NREQ-1:0] mask, input int id,
                           input logic [PW-1:0] p, input bit loop, input int hold,
                           input string name);
    int      exp_err;
    result_t e;
    logic [PW-1:0] b;
    loop_mode = loop;
    req_pattern = '0;
    for (int i = 0; i < NREQ; i++) req_pattern[i*PW +: PW] = (i == id) ? p : PW'(i + 1);
    req_valid = mask;
    #1;
    checks++;
    if (req_ready !== NREQ'(1 << id)) begin
      errors++;
      $display("FAIL %s_grant: got %b want %b", name, req_ready, NREQ'(1 << id));
    end
    exp_err = 0;
    for (int k = 0; k < BL; k++) if (!loop && model_beat(p, k) != '0) exp_err++;
    e = '{id: id, match: (exp_err == 0) && (p != '0), aborted: 1'b0, err: exp_err};
    sb.push_back(e);
    tick;
    req_valid = '0;
    for (int k = 0; k < BL; k++) begin
      b = model_beat(p, k);
      checks++;
      if (gen_active !== 1'b1 || gen_pattern !== b) begin
        errors++;
        $display("FAIL %s_beat%0d: got active=%0b pat=%b want active=1 pat=%b",
                 name, k, gen_active, gen_pattern, b);
      end
      tick;
    end
    checks++;
    if (gen_active !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got active=%0b dv=%0b want 0 0", name, gen_active, done_valid);
    end
    for (int d = 0; d < SL; d++) tick;
    checks++;
    if (done_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_latency: got done_valid=%0b want 1", name, done_valid);
    end
    for (int h = 0; h < hold; h++) begin
      req_valid = '1;
      #1;
      checks++;
      if (done_valid !== 1'b1 || req_ready !== '0 || done_id !== 2'(id) || err_count !== 3'(exp_err)) begin
        errors++;
        $display("FAIL %s_hold%0d: got dv=%0b rdy=%b id=%0d err=%0d want 1 0000 %0d %0d",
                 name, h, done_valid, req_ready, done_id, err_count, id, exp_err);
      end
      tick;
    end
    req_valid  = '0;
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    checks++;
    if (done_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got done_valid=%0b want 0", name, done_valid);
    end
  endtask

  task automatic test_abort;
    result_t e;
    loop_mode   = 1'b1;
    req_pattern = '0;
    req_pattern[0 +: PW] = 3'b101;
    req_valid   = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL abort_grant: got %b want 0001", req_ready);
    end
    e = '{id: 0, match: 1'b0, aborted: 1'b1, err: 0};
    sb.push_back(e);
    tick;
    req_valid = '0;
    tick;
    checks++;
    if (gen_active !== 1'b1 || gen_pattern !== 3'b010) begin
      errors++;
      $display("FAIL abort_beat1: got active=%0b pat=%b want 1 010", gen_active, gen_pattern);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (gen_active !== 1'b0 || gen_pattern !== '0 || done_valid !== 1'b1 ||
        done_aborted !== 1'b1 || done_match !== 1'b0) begin
      errors++;
      $display("FAIL abort_response: got active=%0b pat=%b dv=%0b ab=%0b m=%0b want 0 000 1 1 0",
               gen_active, gen_pattern, done_valid, done_aborted, done_match);
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    abort = 1'b1;
    #1;
    checks++;
    if (done_valid !== 1'b0 || gen_active !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_ignored: got dv=%0b active=%0b want 0 0", done_valid, gen_active);
    end
    tick;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    loop_mode   = 1'b1;
    req_pattern = {3'b001, 3'b001, 3'b110, 3'b001};
    req_valid   = 4'b0010;
    tick;
    req_valid = '0;
    tick;
    reset = 1'b1;
    #1;
    checks++;
    if ({gen_active, gen_pattern, done_valid, done_match, done_aborted, done_id, err_count, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: active=%0b pat=%0d dv=%0b m=%0b ab=%0b id=%0d err=%0d rdy=%b, want all 0",
               gen_active, gen_pattern, done_valid, done_match, done_aborted, done_id, err_count, req_ready);
    end
    tick;
    reset = 1'b0;
    run_burst(4'b1111, 0, 3'b101, 1'b1, 0, "post_reset");
  endtask

  initial begin
    test_reset;
    test_round_robin;
    run_burst(4'b0100, 2, 3'b011, 1'b1, 0, "single");
    run_burst(4'b0010, 1, 3'b001, 1'b0, 0, "mismatch");
    run_burst(4'b1000, 3, 3'b000, 1'b1, 0, "zero_pattern");
    test_abort;
    run_burst(4'b0101, 2, 3'b111, 1'b1, 5, "backpressure");
    test_reset_mid_run;
    repeat (2) tick;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
